// File: rtl/dif_radix2_pkg.sv
// ---------------------------------------------------------------------------
// dif_radix2_pkg
//   Shared definitions for the 64-point radix-2 DIF FFT output frame buffer.
//   - FFT_NUM / FFT_BINS : log2 of points per frame and the bin count
//   - FFT_DATA_WIDTH     : default width of one real/imag component
//   - rd_state_t         : read-side FSM states
//   - cplx_bin_t         : packed complex bin {re, im} at the default width
// ---------------------------------------------------------------------------
package dif_radix2_pkg;

    localparam int FFT_NUM        = 6;
    localparam int FFT_BINS       = 1 << FFT_NUM;
    localparam int FFT_DATA_WIDTH = 17;

    typedef enum logic [0:0] {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_t;

    typedef struct packed {
        logic [FFT_DATA_WIDTH-1:0] re;
        logic [FFT_DATA_WIDTH-1:0] im;
    } cplx_bin_t;

endpackage

// File: rtl/dif_radix2_64p_obuf_bank.sv
// ---------------------------------------------------------------------------
// dif_radix2_64p_obuf_bank
//   Two-bank ping-pong frame store as a single 1W1R synchronous RAM.
//   The address is {bank, idx}; the read port has one cycle of latency.
//   Ports:
//     clk          clock
//     we/waddr/wdata  write port (one write per cycle)
//     re/raddr     read request; rdata valid the cycle after re
//     rdata        registered read data
// ---------------------------------------------------------------------------
module dif_radix2_64p_obuf_bank #(
    parameter int ADDR_WIDTH = 7,
    parameter int WIDTH      = 34
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Plain storage: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dif_radix2_64p_obuf.sv
// ---------------------------------------------------------------------------
// dif_radix2_64p_obuf
//   Output frame buffer behind the 64-point radix-2 DIF FFT. Captures the
//   naturally ordered bin stream into a two-bank ping-pong RAM and replays
//   each completed frame on a valid/ready stream. The FFT cannot be stalled,
//   so a frame arriving while both banks are occupied is dropped whole,
//   flagged on ovf_pulse and counted in drop_cnt (saturating).
//
//   Ports:
//     clk, rst           clock, asynchronous active-high reset
//     din_re/din_im      bin from FFT, qualified by din_valid (no backpressure)
//     m_re/m_im          buffered bin data
//     m_bin              bin index 0..2**FFT_NUM-1
//     m_last             high with the final bin of a frame
//     m_valid/m_ready    output handshake
//     ovf_pulse          one-cycle pulse after the first sample of a dropped frame
//     drop_cnt           dropped-frame count, saturating at all-ones
//     dbg_rd_state       read FSM state, for observation only
//
//   Handshake: a beat transfers on a cycle where m_valid && m_ready. Once
//   m_valid is high, m_valid, m_re, m_im, m_bin and m_last hold their values
//   until that transfer happens; m_valid never depends on m_ready.
// ---------------------------------------------------------------------------
module dif_radix2_64p_obuf
    import dif_radix2_pkg::*;
#(
    parameter int DATA_WIDTH = 17,
    parameter int FFT_NUM    = 6,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din_re,
    input  logic [DATA_WIDTH-1:0] din_im,
    input  logic                  din_valid,
    output logic [DATA_WIDTH-1:0] m_re,
    output logic [DATA_WIDTH-1:0] m_im,
    output logic [FFT_NUM-1:0]    m_bin,
    output logic                  m_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  ovf_pulse,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    output rd_state_t             dbg_rd_state
);

    localparam int WORD_WIDTH = 2 * DATA_WIDTH;

    // -----------------------------------------------------------------------
    // Write side
    // -----------------------------------------------------------------------
    logic [FFT_NUM-1:0] wr_idx;
    logic               wr_bank;
    logic               wr_drop;     // current frame is being discarded
    logic [1:0]         full;
    logic [1:0]         full_nxt;

    logic frame_start;
    logic drop_now;
    logic drop_start;
    logic wr_en;
    logic wr_done;

    assign frame_start = din_valid && (wr_idx == '0);
    // The drop decision is taken once, on the first sample, and then
    // carried for the remaining samples of the frame.
    assign drop_now    = frame_start ? full[wr_bank] : wr_drop;
    assign drop_start  = frame_start && full[wr_bank];
    assign wr_en       = din_valid && !drop_now;
    assign wr_done     = wr_en && (wr_idx == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx    <= '0;
            wr_bank   <= 1'b0;
            wr_drop   <= 1'b0;
            ovf_pulse <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            ovf_pulse <= drop_start;
            if (din_valid) begin
                wr_idx  <= wr_idx + 1'b1;
                wr_drop <= drop_now;
            end
            if (wr_done) begin
                wr_bank <= ~wr_bank;
            end
            if (drop_start && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Bank occupancy. Set by the writer finishing a frame, cleared by the
    // last beat leaving the output. Writer and reader never own the same
    // bank, so set and clear cannot collide on one bit.
    // -----------------------------------------------------------------------
    logic pop;
    logic last_pop;
    logic rd_bank;       // bank whose beats are currently on the output

    assign pop      = m_valid && m_ready;
    assign last_pop = pop && m_last;

    always_comb begin
        full_nxt = full;
        if (last_pop) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (wr_done) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full    <= 2'b00;
            rd_bank <= 1'b0;
        end else begin
            full <= full_nxt;
            if (last_pop) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read issue FSM. The issue pointer (iss_bank, iss_idx) runs up to two
    // beats ahead of the output, which is what lets the next frame be
    // prefetched before the previous frame's last beat is accepted.
    // -----------------------------------------------------------------------
    rd_state_t          state;
    rd_state_t          state_nxt;
    logic [FFT_NUM-1:0] iss_idx;
    logic [FFT_NUM-1:0] iss_idx_nxt;
    logic               iss_bank;
    logic               iss_bank_nxt;
    logic               iss_other;
    logic               rd_en;
    logic               can_issue;

    logic               rd_pend;     // RAM data for a read arrives this cycle
    logic [FFT_NUM-1:0] rd_pend_bin;
    logic               skid_valid;
    logic [1:0]         occ;

    assign iss_other = ~iss_bank;

    // Slots in the two-entry output stage after this edge: occupied entries
    // plus the read in flight, minus the beat leaving now. A new read may be
    // issued only if it will find a free slot when its data returns.
    assign occ       = {1'b0, m_valid} + {1'b0, skid_valid};
    assign can_issue = ({1'b0, occ} + {2'b00, rd_pend}) <= ({2'b00, pop} + 3'd1);

    always_comb begin
        state_nxt    = state;
        iss_idx_nxt  = iss_idx;
        iss_bank_nxt = iss_bank;
        rd_en        = 1'b0;
        case (state)
            RD_IDLE: begin
                if (full[iss_bank]) begin
                    state_nxt = RD_STREAM;
                    rd_en     = can_issue;
                end
            end
            RD_STREAM: begin
                rd_en = can_issue;
            end
            default: begin
                state_nxt = RD_IDLE;
            end
        endcase
        if (rd_en) begin
            iss_idx_nxt = iss_idx + 1'b1;
            if (iss_idx == '1) begin
                iss_bank_nxt = iss_other;
                state_nxt    = full[iss_other] ? RD_STREAM : RD_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RD_IDLE;
            iss_idx     <= '0;
            iss_bank    <= 1'b0;
            rd_pend     <= 1'b0;
            rd_pend_bin <= '0;
        end else begin
            state       <= state_nxt;
            iss_idx     <= iss_idx_nxt;
            iss_bank    <= iss_bank_nxt;
            rd_pend     <= rd_en;
            rd_pend_bin <= iss_idx;
        end
    end

    assign dbg_rd_state = state;

    // -----------------------------------------------------------------------
    // Frame RAM
    // -----------------------------------------------------------------------
    logic [WORD_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] rd_re;
    logic [DATA_WIDTH-1:0] rd_im;
    logic                  rd_last;

    dif_radix2_64p_obuf_bank #(
        .ADDR_WIDTH (FFT_NUM + 1),
        .WIDTH      (WORD_WIDTH)
    ) u_bank (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({wr_bank, wr_idx}),
        .wdata ({din_re, din_im}),
        .re    (rd_en),
        .raddr ({iss_bank, iss_idx}),
        .rdata (rdata)
    );

    assign rd_re   = rdata[WORD_WIDTH-1:DATA_WIDTH];
    assign rd_im   = rdata[DATA_WIDTH-1:0];
    assign rd_last = (rd_pend_bin == '1);

    // -----------------------------------------------------------------------
    // Output stage: the m_* registers are the head, backed by one skid entry.
    // The head reloads whenever it is empty or its beat is leaving; the skid
    // only fills when returning RAM data finds the head stalled.
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] skid_re;
    logic [DATA_WIDTH-1:0] skid_im;
    logic [FFT_NUM-1:0]    skid_bin;
    logic                  skid_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid    <= 1'b0;
            m_re       <= '0;
            m_im       <= '0;
            m_bin      <= '0;
            m_last     <= 1'b0;
            skid_valid <= 1'b0;
            skid_re    <= '0;
            skid_im    <= '0;
            skid_bin   <= '0;
            skid_last  <= 1'b0;
        end else if (!m_valid || pop) begin
            if (skid_valid) begin
                m_valid <= 1'b1;
                m_re    <= skid_re;
                m_im    <= skid_im;
                m_bin   <= skid_bin;
                m_last  <= skid_last;
            end else begin
                m_valid <= rd_pend;
                if (rd_pend) begin
                    m_re   <= rd_re;
                    m_im   <= rd_im;
                    m_bin  <= rd_pend_bin;
                    m_last <= rd_last;
                end
            end
            // Skid drained into the head; refill it only if RAM data also
            // arrives this cycle.
            skid_valid <= skid_valid && rd_pend;
            if (skid_valid && rd_pend) begin
                skid_re   <= rd_re;
                skid_im   <= rd_im;
                skid_bin  <= rd_pend_bin;
                skid_last <= rd_last;
            end
        end else if (rd_pend) begin
            skid_valid <= 1'b1;
            skid_re    <= rd_re;
            skid_im    <= rd_im;
            skid_bin   <= rd_pend_bin;
            skid_last  <= rd_last;
        end
    end

endmodule

// File: tb/tb_dif_radix2_64p_obuf.sv
// ---------------------------------------------------------------------------
// tb_dif_radix2_64p_obuf
//   Self-checking bench for dif_radix2_64p_obuf. The reference model works
//   at frame level: a frame is kept if fewer than two completed frames are
//   still waiting to be fully read out when its first sample arrives; kept
//   frames are queued beat by beat in exp_q, dropped frames raise ovf_pulse
//   one cycle later and bump a saturating count. The drop counter is built
//   narrow here so saturation can be reached in a short run.
// ---------------------------------------------------------------------------
module tb_dif_radix2_64p_obuf;
    import dif_radix2_pkg::*;

    localparam int DW   = FFT_DATA_WIDTH;
    localparam int FN   = FFT_NUM;
    localparam int NB   = FFT_BINS;
    localparam int CW   = 4;
    localparam int EW   = 1 + FN + 2 * DW;   // {last, bin, re, im}

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din_re;
    logic [DW-1:0] din_im;
    logic          din_valid;
    logic [DW-1:0] m_re;
    logic [DW-1:0] m_im;
    logic [FN-1:0] m_bin;
    logic          m_last;
    logic          m_valid;
    logic          m_ready;
    logic          ovf_pulse;
    logic [CW-1:0] drop_cnt;
    rd_state_t     dbg_state;

    always #5 clk = ~clk;

    dif_radix2_64p_obuf #(
        .DATA_WIDTH (DW),
        .FFT_NUM    (FN),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .din_re       (din_re),
        .din_im       (din_im),
        .din_valid    (din_valid),
        .m_re         (m_re),
        .m_im         (m_im),
        .m_bin        (m_bin),
        .m_last       (m_last),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .ovf_pulse    (ovf_pulse),
        .drop_cnt     (drop_cnt),
        .dbg_rd_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int             checks   = 0;
    int             failures = 0;
    logic [EW-1:0]  exp_q[$];
    cplx_bin_t      frame_buf [NB];
    int             stored   = 0;
    int             widx     = 0;
    bit             cur_drop = 1'b0;
    logic [CW-1:0]  exp_drop = '0;
    bit             ovf_exp  = 1'b0;
    bit             held     = 1'b0;
    logic [EW-1:0]  held_beat;
    logic [EW-1:0]  mon_e;
    int             beats    = 0;
    bit             rand_rdy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitor / reference model ----------------
    // Runs on the falling edge: everything seen here is what the next rising
    // edge will sample.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                stored   = 0;
                widx     = 0;
                cur_drop = 1'b0;
                exp_drop = '0;
                ovf_exp  = 1'b0;
                held     = 1'b0;
            end else begin
                chk("ovf_pulse", 64'(ovf_pulse), 64'(ovf_exp));
                chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
                if (held) begin
                    chk("hold_stable", 64'({m_valid, m_last, m_bin, m_re, m_im}),
                        64'({1'b1, held_beat}));
                end
                held      = m_valid && !m_ready;
                held_beat = {m_last, m_bin, m_re, m_im};

                // Output side: compare and retire, but only free the frame
                // after the write-side decision below has used the old count.
                mon_e = '0;
                if (m_valid && m_ready) begin
                    beats++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 64'(1), 64'(0));
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("beat", 64'({m_last, m_bin, m_re, m_im}), 64'(mon_e));
                    end
                end

                ovf_exp = 1'b0;
                if (din_valid) begin
                    if (widx == 0) begin
                        cur_drop = (stored == 2);
                        if (cur_drop) begin
                            ovf_exp = 1'b1;
                            if (exp_drop != '1) exp_drop = exp_drop + 1'b1;
                        end
                    end
                    if (!cur_drop) frame_buf[widx] = {din_re, din_im};
                    if (widx == NB - 1) begin
                        if (!cur_drop) begin
                            for (int k = 0; k < NB; k++)
                                exp_q.push_back({(k == NB - 1), FN'(k), frame_buf[k]});
                            stored++;
                        end
                        widx = 0;
                    end else begin
                        widx++;
                    end
                end
                if (mon_e[EW-1]) stored--;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_ready();
        if (rand_rdy) m_ready = ($urandom_range(0, 1) == 1);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        set_ready();
    endtask

    task automatic drive_sample(input logic [DW-1:0] re, input logic [DW-1:0] im);
        @(posedge clk);
        #1;
        din_valid = 1'b1;
        din_re    = re;
        din_im    = im;
        set_ready();
    endtask

    task automatic drive_frame(input bit ramp, input bit gaps);
        for (int k = 0; k < NB; k++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) idle_cycle();
            end
            if (ramp) drive_sample(DW'(k), DW'(-k));
            else      drive_sample(DW'($urandom), DW'($urandom));
        end
    endtask

    task automatic drain(input int max_cycles, input string tag);
        bit done = 1'b0;
        for (int c = 0; c < max_cycles && !done; c++) begin
            @(posedge clk);
            #1;
            din_valid = 1'b0;
            set_ready();
            @(negedge clk);
            if (exp_q.size() == 0 && m_valid === 1'b0) done = 1'b1;
        end
        chk(tag, 64'(done), 64'(1));
    endtask

    task automatic wait_valid(input int max_cycles, input string tag);
        for (int c = 0; c < max_cycles && m_valid !== 1'b1; c++) @(negedge clk);
        chk(tag, 64'(m_valid), 64'(1));
    endtask

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    int base_beats;

    initial begin : stimulus
        rst       = 1'b1;
        din_valid = 1'b0;
        din_re    = '0;
        din_im    = '0;
        m_ready   = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_m_last", 64'(m_last), 64'(0));
        chk("rst_m_bin", 64'(m_bin), 64'(0));
        chk("rst_m_re", 64'(m_re), 64'(0));
        chk("rst_m_im", 64'(m_im), 64'(0));
        chk("rst_ovf", 64'(ovf_pulse), 64'(0));
        chk("rst_drop_cnt", 64'(drop_cnt), 64'(0));
        chk("rst_state", 64'(dbg_state), 64'(RD_IDLE));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single ramp frame: latency and 64 contiguous beats
        m_ready = 1'b1;
        drive_frame(1'b1, 1'b0);
        idle_cycle();                       // this edge samples bin 63
        @(negedge clk);
        chk("lat_edge0", 64'(m_valid), 64'(0));
        @(negedge clk);
        chk("lat_edge1", 64'(m_valid), 64'(0));
        @(negedge clk);
        chk("lat_edge2", 64'(m_valid), 64'(1));
        for (int i = 1; i < NB; i++) begin
            @(negedge clk);
            chk("single_contig", 64'(m_valid), 64'(1));
        end
        @(negedge clk);
        chk("single_end", 64'(m_valid), 64'(0));
        chk("single_drop", 64'(drop_cnt), 64'(0));
        drain(50, "single_drain");

        // Two back-to-back frames: 128 beats without a bubble
        fork
            begin
                drive_frame(1'b0, 1'b0);
                drive_frame(1'b0, 1'b0);
                idle_cycle();
            end
            begin
                wait_valid(200, "b2b_start");
                for (int i = 1; i < 2 * NB; i++) begin
                    @(negedge clk);
                    chk("b2b_contig", 64'(m_valid), 64'(1));
                end
            end
        join
        drain(50, "b2b_drain");
        chk("b2b_drop", 64'(drop_cnt), 64'(0));

        // Three frames with the consumer stalled: third one is dropped
        m_ready = 1'b0;
        drive_frame(1'b0, 1'b0);
        drive_frame(1'b0, 1'b0);
        drive_frame(1'b0, 1'b0);
        idle_cycle();
        repeat (3) idle_cycle();
        chk("stall_drop_cnt", 64'(drop_cnt), 64'(1));
        chk("stall_valid_held", 64'(m_valid), 64'(1));
        m_ready = 1'b1;
        drain(400, "stall_drain");

        // Random ready and input gaps over ten frames
        rand_rdy = 1'b1;
        for (int f = 0; f < 10; f++) drive_frame(1'b0, 1'b1);
        drain(3000, "rand_drain");
        rand_rdy = 1'b0;
        m_ready  = 1'b1;
        chk("rand_state_idle", 64'(dbg_state), 64'(RD_IDLE));

        // Reset in the middle of a readout
        base_beats = beats;
        drive_frame(1'b1, 1'b0);
        idle_cycle();
        for (int c = 0; c < 200 && (beats - base_beats) < 30; c++) @(negedge clk);
        chk("rst_mid_reached", 64'((beats - base_beats) >= 30), 64'(1));
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 64'(m_valid), 64'(0));
        chk("rst_mid_drop_cnt", 64'(drop_cnt), 64'(0));
        chk("rst_mid_state", 64'(dbg_state), 64'(RD_IDLE));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive_frame(1'b1, 1'b0);
        idle_cycle();
        wait_valid(10, "post_rst_start");
        chk("post_rst_bin0", 64'(m_bin), 64'(0));
        drain(200, "post_rst_drain");

        // Drop-counter saturation: 2 kept frames, 2**CW+3 dropped
        m_ready = 1'b0;
        for (int f = 0; f < 2 + (1 << CW) + 3; f++) drive_frame(1'b0, 1'b0);
        idle_cycle();
        idle_cycle();
        chk("sat_drop_cnt", 64'(drop_cnt), 64'({CW{1'b1}}));
        m_ready = 1'b1;
        drain(400, "sat_drain");
        chk("sat_drop_hold", 64'(drop_cnt), 64'({CW{1'b1}}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
